mem_access_unit: RTL

Initiator-side controller for the single-port synchronous data memory: it accepts byte, halfword and word load/store requests from the CPU datapath on a valid/ready handshake. It converts byte addresses to word addresses, performs lane extraction with sign/zero extension, and implements sub-word stores as read-modify-write sequences. It sits between the execute/memory pipeline stage and the data memory, and is the only block that drives the memory's address, data-in and write-enable.

---
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/mem_access_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signal bundle for mem_access_unit.
// slave is the unit's view; master is the CPU-plus-memory side.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH+1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_dataIn;
    logic                  mem_we;
    logic [31:0]           mem_dataOut;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_dataOut,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_dataIn, mem_we
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_dataOut,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_dataIn, mem_we
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store controller for a single-port synchronous data memory: lane extraction
// with sign/zero extension on loads, read-modify-write for byte/halfword stores.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_unit_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_RD_CAP, S_RMW_RD, S_RMW_CAP, S_WR, S_ERR
    } state_t;

    state_t                r_state;
    logic [1:0]            r_lane;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [31:0]           r_wdata;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [31:0]           r_resp_rdata;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_din;
    logic                  r_mem_we;
    logic                  w_illegal;

    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic sgn);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh = word >> {lane, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (size)
            2'b00:   f_extract = sgn ? 32'(b) : {24'd0, sh[7:0]};
            2'b01:   f_extract = sgn ? 32'(h) : {16'd0, sh[15:0]};
            default: f_extract = word;
        endcase
    endfunction

    // Halfwords are aligned here, so lane is 0 or 2 and the byte shift serves both sizes.
    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wdata,
                                            input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] mask;
        logic [31:0] data;
        mask    = (size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        mask    = mask << {lane, 3'b000};
        data    = wdata << {lane, 3'b000};
        f_merge = (old & ~mask) | (data & mask);
    endfunction

    assign w_illegal = (bus.req_size == 2'b11) ||
                       (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                       (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_lane       <= 2'b00;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_wdata      <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_mem_addr   <= '0;
            r_mem_din    <= 32'd0;
            r_mem_we     <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_mem_we     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_lane   <= bus.req_addr[1:0];
                        r_size   <= bus.req_size;
                        r_signed <= bus.req_signed;
                        r_wdata  <= bus.req_wdata;
                        if (w_illegal) begin
                            r_state <= S_ERR;
                        end else begin
                            r_mem_addr <= bus.req_addr[ADDR_WIDTH+1:2];
                            if (!bus.req_write) begin
                                r_state <= S_RD;
                            end else if (bus.req_size == 2'b10) begin
                                // Full-word store goes straight to the write cycle.
                                r_mem_din <= bus.req_wdata;
                                r_mem_we  <= 1'b1;
                                r_state   <= S_WR;
                            end else begin
                                r_state <= S_RMW_RD;
                            end
                        end
                    end
                end
                S_RD:     r_state <= S_RD_CAP;
                S_RMW_RD: r_state <= S_RMW_CAP;
                S_RD_CAP: begin
                    r_resp_rdata <= f_extract(bus.mem_dataOut, r_lane, r_size, r_signed);
                    r_resp_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                S_RMW_CAP: begin
                    r_mem_din <= f_merge(bus.mem_dataOut, r_wdata, r_lane, r_size);
                    r_mem_we  <= 1'b1;
                    r_state   <= S_WR;
                end
                S_WR: begin
                    r_resp_rdata <= 32'd0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                S_ERR: begin
                    r_resp_rdata <= 32'd0;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_err    = r_resp_err;
    assign bus.resp_rdata  = r_resp_rdata;
    assign bus.mem_address = r_mem_addr;
    assign bus.mem_dataIn  = r_mem_din;
    assign bus.mem_we      = r_mem_we;
endmodule
